// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over a
// valid/ready port with in-order variable-latency responses, buffers
// returned instructions with their PCs, and handles redirects by
// flushing the buffer and discarding stale in-flight responses.
module instr_fetch_unit #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   output logic [PC_W-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] instr_pc,
   output logic [PC_W-1:0] instr_pc4,
   input  logic            instr_ready,
   output logic [PC_W-1:0] pc_out
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

   state_t            state_q;
   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d;
   logic [PTR_W-1:0]  fifo_rd_q, fifo_rd_d;
   logic [PTR_W-1:0]  pcq_wr_q, pcq_rd_q;

   logic [31:0]       fifo_data_q [DEPTH];
   logic [PC_W-1:0]   fifo_pc_q   [DEPTH];
   logic [PC_W-1:0]   pcq_mem_q   [DEPTH];

   logic [CNT_W:0]    occupancy;
   logic              req_fire;
   logic              rsp_drop;
   logic              fifo_push;
   logic              fifo_pop;
   logic              unused_redirect_low;

   // The low two redirect bits are forced to zero, so they are never read.
   assign unused_redirect_low = ^redirect_pc[1:0];

   // Space is reserved for every outstanding request, so the FIFO cannot overflow.
   assign occupancy      = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
   assign imem_req_valid = (state_q != BOOT) && (occupancy < DEPTH_W) && !redirect_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign pc_out         = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response in the redirect cycle belongs to the old path and is dropped too.
   assign rsp_drop  = imem_rsp_valid && ((drop_cnt_q != '0) || redirect_valid);
   assign fifo_push = imem_rsp_valid && !rsp_drop;
   assign fifo_pop  = instr_valid && instr_ready;

   // Decode sees the FIFO head; an empty FIFO presents zeros.
   assign instr_valid = (fifo_count_q != '0);
   assign instr       = instr_valid ? fifo_data_q[fifo_rd_q] : 32'h0;
   assign instr_pc    = instr_valid ? fifo_pc_q[fifo_rd_q] : '0;
   assign instr_pc4   = instr_pc + PC_W'(4);

   // Next-state arithmetic for counters, FIFO pointers and the fetch PC.
   always_comb begin
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      drop_cnt_d    = drop_cnt_q;
      fifo_count_d  = fifo_count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      fifo_wr_d     = fifo_push ? fifo_wr_q + PTR_W'(1) : fifo_wr_q;
      fifo_rd_d     = fifo_pop  ? fifo_rd_q + PTR_W'(1) : fifo_rd_q;
      fetch_pc_d    = req_fire  ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
      if (redirect_valid) begin
         // Every request still in flight after this cycle is from the old path.
         drop_cnt_d   = outstanding_d;
         fifo_count_d = '0;
         fifo_rd_d    = fifo_wr_q;
         fetch_pc_d   = {redirect_pc[PC_W-1:2], 2'b00};
      end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
   end

   // Boot/run/flush sequencing; BOOT holds off fetch for one cycle after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
      end else begin
         case (state_q)
            BOOT:    state_q <= RUN;
            RUN:     if (redirect_valid && (drop_cnt_d != '0)) state_q <= FLUSH;
            FLUSH:   if (!redirect_valid && (drop_cnt_d == '0)) state_q <= RUN;
            default: state_q <= BOOT;
         endcase
      end
   end

   // Counters, pointers and the program counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         fifo_count_q  <= '0;
         fifo_wr_q     <= '0;
         fifo_rd_q     <= '0;
         pcq_wr_q      <= '0;
         pcq_rd_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         fifo_count_q  <= fifo_count_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_rd_q     <= fifo_rd_d;
         if (req_fire)       pcq_wr_q <= pcq_wr_q + PTR_W'(1);
         if (imem_rsp_valid) pcq_rd_q <= pcq_rd_q + PTR_W'(1);
      end
   end

   // Per-entry storage: the PC queue remembers each request address until
   // its response returns, and the FIFO keeps instruction plus PC.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the request PC when the request is accepted.
      always_ff @(posedge clk) begin
         if (req_fire && (pcq_wr_q == PTR_W'(gi))) begin
            pcq_mem_q[gi] <= fetch_pc_q;
         end
      end

      // Write a kept response and its request PC at the FIFO tail.
      always_ff @(posedge clk) begin
         if (fifo_push && (fifo_wr_q == PTR_W'(gi))) begin
            fifo_data_q[gi] <= imem_rsp_data;
            fifo_pc_q[gi]   <= pcq_mem_q[pcq_rd_q];
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: an in-order variable-latency
// memory model plus a stream-level reference (decode must see consecutive
// PCs starting at the reset PC or the latest redirect target).
module tb_instr_fetch_unit;
   localparam int          DEPTH = 2;
   localparam logic [15:0] RST_PC = 16'h0040;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [15:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [15:0] instr_pc;
   logic [15:0] instr_pc4;
   logic        instr_ready;
   logic [15:0] pc_out;

   instr_fetch_unit #(.PC_W(16), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .instr_pc4(instr_pc4), .instr_ready(instr_ready),
      .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } mreq_t;

   mreq_t       memq[$];
   logic [15:0] acc_log[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          pops = 0;
   int          rdy_pct = 100, dec_pct = 100, lat_min = 1, lat_max = 1;
   logic [15:0] exp_req_pc, exp_dec_pc;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_instr;
   logic [15:0] prev_pc;
   logic        st_req_valid, st_acc, st_pop, st_rsp;
   logic [15:0] st_acc_addr, st_pop_pc, st_pop_pc4;
   logic [31:0] st_pop_instr;

   function automatic logic [31:0] word_of(input logic [15:0] a);
      return {a ^ 16'hC35A, ~a};
   endfunction

   // One clock cycle: drive inputs, sample, take the edge, update the models.
   task automatic step(input logic redir, input logic [15:0] rpc);
      logic [15:0] want_pc4;
      logic [15:0] tgt;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      instr_ready    = ($urandom_range(99) < dec_pct);
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (memq.size() > 0 && memq[0].due <= cyc + 1) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_of(memq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #1;
      if (prev_hold) begin
         total++;
         if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc) begin
            bad++;
            $display("FAIL hold_stable: got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h",
                     instr_valid, instr, instr_pc, prev_instr, prev_pc);
         end
      end
      st_req_valid = imem_req_valid;
      st_acc       = imem_req_valid && imem_req_ready;
      st_acc_addr  = imem_req_addr;
      st_pop       = instr_valid && instr_ready;
      st_pop_pc    = instr_pc;
      st_pop_pc4   = instr_pc4;
      st_pop_instr = instr;
      st_rsp       = imem_rsp_valid;
      prev_hold    = instr_valid && !instr_ready && !redir;
      prev_instr   = instr;
      prev_pc      = instr_pc;
      @(posedge clk);
      cyc++;
      if (st_rsp) memq.delete(0);
      if (st_pop) begin
         pops++;
         want_pc4 = exp_dec_pc + 16'd4;
         total++;
         if (st_pop_pc !== exp_dec_pc) begin
            bad++;
            $display("FAIL instr_pc: got %h want %h", st_pop_pc, exp_dec_pc);
         end
         total++;
         if (st_pop_instr !== word_of(exp_dec_pc)) begin
            bad++;
            $display("FAIL instr_data: got %h want %h", st_pop_instr, word_of(exp_dec_pc));
         end
         total++;
         if (st_pop_pc4 !== want_pc4) begin
            bad++;
            $display("FAIL instr_pc4: got %h want %h", st_pop_pc4, want_pc4);
         end
         exp_dec_pc = want_pc4;
      end
      if (redir) begin
         total++;
         if (st_acc !== 1'b0) begin
            bad++;
            $display("FAIL req_in_redirect: got %b want 0", st_acc);
         end
         tgt = {rpc[15:2], 2'b00};
         exp_req_pc = tgt;
         exp_dec_pc = tgt;
      end else if (st_acc) begin
         acc_log.push_back(st_acc_addr);
         total++;
         if (st_acc_addr !== exp_req_pc) begin
            bad++;
            $display("FAIL req_addr: got %h want %h", st_acc_addr, exp_req_pc);
         end
         memq.push_back('{st_acc_addr, cyc + int'($urandom_range(lat_max, lat_min))});
         exp_req_pc = exp_req_pc + 16'd4;
         total++;
         if (memq.size() > DEPTH) begin
            bad++;
            $display("FAIL outstanding_limit: got %0d want <=%0d", memq.size(), DEPTH);
         end
      end
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 16'h0; instr_ready = 1'b0;
      repeat (n) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      memq.delete();
      acc_log.delete();
      exp_req_pc = RST_PC;
      exp_dec_pc = RST_PC;
      prev_hold = 1'b0;
      total++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_quiet: got req=%b iv=%b want 0 0", imem_req_valid, instr_valid);
      end
   endtask

   task automatic release_boot();
      reset = 1'b0;
      step(1'b0, 16'h0);
      total++;
      if (st_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL boot_no_req: got %b want 0", st_req_valid);
      end
   endtask

   task automatic test_reset();
      rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1;
      apply_reset(3);
      total++;
      if (imem_req_addr !== RST_PC || pc_out !== RST_PC || instr !== 32'h0 ||
          instr_pc !== 16'h0 || instr_pc4 !== 16'h4) begin
         bad++;
         $display("FAIL reset_values: got addr=%h pc_out=%h instr=%h pc=%h pc4=%h want %h %h 0 0 4",
                  imem_req_addr, pc_out, instr, instr_pc, instr_pc4, RST_PC, RST_PC);
      end
      release_boot();
      step(1'b0, 16'h0);
      total++;
      if (st_acc !== 1'b1 || st_acc_addr !== RST_PC) begin
         bad++;
         $display("FAIL first_req: got acc=%b addr=%h want 1 %h", st_acc, st_acc_addr, RST_PC);
      end
      total++;
      if (instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL no_bypass: got %b want 0", instr_valid);
      end
      step(1'b0, 16'h0);
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== RST_PC) begin
         bad++;
         $display("FAIL rsp_latency: got v=%b pc=%h want 1 %h", instr_valid, instr_pc, RST_PC);
      end
      repeat (5) step(1'b0, 16'h0);
      total++;
      if (acc_log.size() < 3 || acc_log[0] !== 16'h0040 || acc_log[1] !== 16'h0044 ||
          acc_log[2] !== 16'h0048) begin
         bad++;
         $display("FAIL boot_sequence: got %0d reqs first=%h want 0040 0044 0048",
                  acc_log.size(), (acc_log.size() > 0) ? acc_log[0] : 16'hxxxx);
      end
   endtask

   task automatic test_streaming();
      logic        saw_wrap;
      logic [15:0] last_pc;
      int          start_pops;
      rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1;
      apply_reset(2);
      release_boot();
      start_pops = pops;
      repeat (30) step(1'b0, 16'h0);
      total++;
      if (pops - start_pops < 12) begin
         bad++;
         $display("FAIL stream_progress: got %0d want >=12", pops - start_pops);
      end
      step(1'b1, 16'hFFF2);
      saw_wrap = 1'b0;
      last_pc = 16'h0;
      for (int i = 0; i < 25; i++) begin
         step(1'b0, 16'h0);
         if (st_pop) begin
            if (last_pc == 16'hFFFC && st_pop_pc == 16'h0000) saw_wrap = 1'b1;
            last_pc = st_pop_pc;
         end
      end
      total++;
      if (saw_wrap !== 1'b1) begin
         bad++;
         $display("FAIL pc_wrap: got %b want 1", saw_wrap);
      end
   endtask

   task automatic test_backpressure();
      int accs;
      int start_pops;
      rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 2;
      apply_reset(2);
      release_boot();
      repeat (6) step(1'b0, 16'h0);
      dec_pct = 0;
      accs = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 16'h0);
         if (st_acc) accs++;
      end
      total++;
      if (instr_valid !== 1'b1 || accs > DEPTH) begin
         bad++;
         $display("FAIL backpressure: got v=%b accs=%0d want 1 <=%0d", instr_valid, accs, DEPTH);
      end
      dec_pct = 100;
      start_pops = pops;
      repeat (15) step(1'b0, 16'h0);
      total++;
      if (pops - start_pops < 4) begin
         bad++;
         $display("FAIL bp_release: got %0d want >=4", pops - start_pops);
      end
   endtask

   task automatic test_redirect_inflight();
      logic got;
      rdy_pct = 100; dec_pct = 100; lat_min = 3; lat_max = 3;
      apply_reset(2);
      release_boot();
      step(1'b0, 16'h0);
      step(1'b0, 16'h0);
      total++;
      if (memq.size() != 2) begin
         bad++;
         $display("FAIL inflight_setup: got %0d want 2", memq.size());
      end
      step(1'b1, 16'h0123);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step(1'b0, 16'h0);
         if (st_pop) got = 1'b1;
      end
      total++;
      if (!got || st_pop_pc !== 16'h0120) begin
         bad++;
         $display("FAIL redirect_first: got pop=%b pc=%h want 1 0120", got, st_pop_pc);
      end
   endtask

   task automatic test_redirect_consume();
      logic found;
      rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1;
      apply_reset(2);
      release_boot();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid && memq.size() > 0 && memq[0].due <= cyc + 1) begin
            step(1'b1, 16'h0200);
            found = 1'b1;
         end else begin
            step(1'b0, 16'h0);
         end
      end
      total++;
      if (!found || st_pop !== 1'b1 || st_rsp !== 1'b1) begin
         bad++;
         $display("FAIL rc_setup: got found=%b pop=%b rsp=%b want 1 1 1", found, st_pop, st_rsp);
      end
      total++;
      if (instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL rc_flushed: got %b want 0", instr_valid);
      end
      #1;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0200) begin
         bad++;
         $display("FAIL rc_restart: got v=%b addr=%h want 1 0200", imem_req_valid, imem_req_addr);
      end
      repeat (12) step(1'b0, 16'h0);
   endtask

   task automatic test_reset_flush();
      logic got;
      rdy_pct = 100; dec_pct = 100; lat_min = 4; lat_max = 4;
      apply_reset(2);
      release_boot();
      step(1'b0, 16'h0);
      step(1'b0, 16'h0);
      step(1'b1, 16'h0300);
      step(1'b0, 16'h0);
      apply_reset(2);
      total++;
      if (pc_out !== RST_PC) begin
         bad++;
         $display("FAIL flush_reset_pc: got %h want %h", pc_out, RST_PC);
      end
      lat_min = 1; lat_max = 1;
      release_boot();
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step(1'b0, 16'h0);
         if (st_pop) got = 1'b1;
      end
      total++;
      if (!got || st_pop_pc !== RST_PC) begin
         bad++;
         $display("FAIL flush_reset_restart: got pop=%b pc=%h want 1 %h", got, st_pop_pc, RST_PC);
      end
   endtask

   task automatic test_random();
      int start_pops;
      rdy_pct = 70; dec_pct = 65; lat_min = 1; lat_max = 4;
      apply_reset(2);
      release_boot();
      start_pops = pops;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 4) step(1'b1, 16'($urandom));
         else step(1'b0, 16'h0);
      end
      total++;
      if (pops - start_pops < 100) begin
         bad++;
         $display("FAIL random_progress: got %0d want >=100", pops - start_pops);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_consume();
      test_reset_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
